rob_retire_unit: RTL and testbench
==================================

Name: rob_retire_unit

Overview:
- In-order reorder buffer directly downstream of the memory/complete register stage.
- Allocates entries at dispatch (2 per cycle).
- Marks entries complete from the three complete ports (ALU0, ALU1, ALU2/LSQ/datamem).
- Retires up to 2 completed entries per cycle in program order to the architectural state, the free list and the store commit path.

Parameters:
- DEPTH, 64, number of ROB entries; power of two, max 64 (ROBNum is 6 bits).
- PTR_W, 6, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- alloc0_valid_in, alloc1_valid_in  input  1 each  dispatch slot requests an entry; slot 1 is younger
- alloc0_PC_in, alloc1_PC_in  input  32 each  instruction PC
- alloc0_archReg_in, alloc1_archReg_in  input  5 each  architectural destination
- alloc0_destReg_in, alloc1_destReg_in  input  6 each  new physical destination; 0 means no register write
- alloc0_oldDestReg_in, alloc1_oldDestReg_in  input  6 each  previous mapping, released at retire
- alloc0_isStore_in, alloc1_isStore_in  input  1 each  entry is a store
- alloc_ready_out  output  1  at least 2 free entries
- alloc0_ROBNum_out, alloc1_ROBNum_out  output  6 each  entry numbers granted (tail, tail+1)
- PC_complete{0,1,2}_in  input  32 each  complete-port PC; nonzero means valid
- ROBNum_complete{0,1,2}_in  input  6 each  entry being completed
- destReg_data_complete{0,1,2}_in  input  32 each  result value
- retire{0,1}_valid_out  output  1 each  slot retires this cycle
- retire{0,1}_PC_out  output  32 each  retired PC
- retire{0,1}_archReg_out  output  5 each  architectural register
- retire{0,1}_physReg_out  output  6 each  physical register
- retire{0,1}_oldPhysReg_out  output  6 each  register returned to the free list
- retire{0,1}_data_out  output  32 each  committed value
- retire{0,1}_wen_out  output  1 each  valid and physReg != 0
- retire{0,1}_isStore_out  output  1 each  store commit to the LSQ
- rob_empty_out  output  1  count == 0

Behaviour:
- State per entry: valid, complete, PC, archReg, destReg, oldDestReg, isStore, data.
- State pointers: head, tail (PTR_W bits, wrap modulo DEPTH) and count (PTR_W+1 bits).
- Reset:
  - All entries invalid; head = tail = count = 0.
  - All retire outputs 0; rob_empty_out = 1; alloc_ready_out = 1; alloc ROBNum outputs = 0 and 1.
- alloc_ready_out = (DEPTH - count >= 2), computed combinationally from registered count.
- Allocation happens only when alloc_ready_out = 1.
  - If alloc0 is set: it takes tail; alloc1, if set, takes tail+1.
  - If only alloc1 is set: it takes tail.
  - Entry written valid=1, complete=0; tail advances by the number allocated.
  - alloc*_ROBNum_out are combinational from tail.
  - alloc_valid while not ready: ignored, no state change.
- Completion, per port, on every posedge:
  - Port is valid when PC_complete != 0.
  - Sets complete=1 and data on entry ROBNum.
  - Ignored if the entry is not valid or already complete (first completion wins).
- Two ports naming the same ROBNum in one cycle: lowest port index wins.
- Stores complete through port 2 with destReg 0; data is don't-care and is stored as received.
- Retire evaluates pre-edge state on every posedge:
  - Slot 0 retires head if valid && complete.
  - Slot 1 retires head+1 only if slot 0 retires and head+1 is valid && complete.
  - Retired entries are invalidated; head and count update.
  - Retire outputs are registered: they reflect entries retired at this edge and hold 0 (valid=0, all fields 0) otherwise.
- Latency:
  - Completion at edge N to the head entry gives retire{0}_valid_out high after edge N+1.
  - No bypass from complete ports to retire.
- Simultaneous events:
  - Same-edge count update: count_next = count + allocs - retires.
  - Allocation into slots freed at the same edge is not allowed; alloc_ready_out uses pre-edge count.
- Wrap-around: head+1 and tail+1 computed modulo DEPTH; DEPTH entries fully usable.
- rstn deassertion mid-operation: all in-flight entries discarded; state returns to reset values asynchronously.

Optional Feature:
- Macro ROB_PERF_CNT_EN.
- When defined: adds output retired_count_out (32 bits), reset 0, incremented by the number retired each cycle and wrapping at 2^32. Also adds output full_stall_count_out (32 bits), incremented each cycle with any alloc_valid high and alloc_ready_out low.
- When undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset then alloc0+alloc1 (PC 0x100/0x104, destReg 5/6) -> ROBNum 0/1 granted, count=2, rob_empty_out=0, nothing retires.
- Complete ROB 1 (data 0xAA) before ROB 0 (data 0x55) -> no retire after the first; after completing ROB 0, both retire in the same cycle: slot0 PC 0x100 data 0x55, slot1 PC 0x104 data 0xAA.
- Allocate 64 entries without completion -> alloc_ready_out falls at count 63; further alloc_valid ignored; tail unchanged.
- Run 70 alloc/complete/retire cycles -> pointers wrap past 63 to 0; retire order matches allocation order; count returns to 0.
- Ports 0 and 2 complete ROB 3 in the same cycle with 0x11/0x22, then port 1 sends 0x33 -> retired data 0x11.
- Store at ROB 4 completed via port 2 with destReg 0 -> retire0_isStore_out=1, retire0_wen_out=0; rstn pulsed mid-stream -> all outputs zero, rob_empty_out=1.

Source files
------------

// File: rtl/rob_retire_unit_if.sv
// Bundle of the dispatch, complete and retire signals of rob_retire_unit.
//   master : dispatch/complete driver (allocation requests, complete ports), sees retire results
//   slave  : the reorder buffer itself
// Signals:
//   alloc{0,1}_*        dispatch slot requests (slot 1 is younger), alloc_ready_out, ROBNum grants
//   *_complete{0,1,2}_in complete ports, a port is valid when its PC is nonzero
//   retire{0,1}_*       registered retire results, rob_empty_out
interface rob_retire_unit_if;
    logic        alloc0_valid_in;
    logic        alloc1_valid_in;
    logic [31:0] alloc0_PC_in;
    logic [31:0] alloc1_PC_in;
    logic [4:0]  alloc0_archReg_in;
    logic [4:0]  alloc1_archReg_in;
    logic [5:0]  alloc0_destReg_in;
    logic [5:0]  alloc1_destReg_in;
    logic [5:0]  alloc0_oldDestReg_in;
    logic [5:0]  alloc1_oldDestReg_in;
    logic        alloc0_isStore_in;
    logic        alloc1_isStore_in;
    logic        alloc_ready_out;
    logic [5:0]  alloc0_ROBNum_out;
    logic [5:0]  alloc1_ROBNum_out;

    logic [31:0] PC_complete0_in;
    logic [31:0] PC_complete1_in;
    logic [31:0] PC_complete2_in;
    logic [5:0]  ROBNum_complete0_in;
    logic [5:0]  ROBNum_complete1_in;
    logic [5:0]  ROBNum_complete2_in;
    logic [31:0] destReg_data_complete0_in;
    logic [31:0] destReg_data_complete1_in;
    logic [31:0] destReg_data_complete2_in;

    logic        retire0_valid_out;
    logic        retire1_valid_out;
    logic [31:0] retire0_PC_out;
    logic [31:0] retire1_PC_out;
    logic [4:0]  retire0_archReg_out;
    logic [4:0]  retire1_archReg_out;
    logic [5:0]  retire0_physReg_out;
    logic [5:0]  retire1_physReg_out;
    logic [5:0]  retire0_oldPhysReg_out;
    logic [5:0]  retire1_oldPhysReg_out;
    logic [31:0] retire0_data_out;
    logic [31:0] retire1_data_out;
    logic        retire0_wen_out;
    logic        retire1_wen_out;
    logic        retire0_isStore_out;
    logic        retire1_isStore_out;
    logic        rob_empty_out;

    modport master (
        output alloc0_valid_in, alloc1_valid_in, alloc0_PC_in, alloc1_PC_in,
               alloc0_archReg_in, alloc1_archReg_in, alloc0_destReg_in, alloc1_destReg_in,
               alloc0_oldDestReg_in, alloc1_oldDestReg_in, alloc0_isStore_in, alloc1_isStore_in,
               PC_complete0_in, PC_complete1_in, PC_complete2_in,
               ROBNum_complete0_in, ROBNum_complete1_in, ROBNum_complete2_in,
               destReg_data_complete0_in, destReg_data_complete1_in, destReg_data_complete2_in,
        input  alloc_ready_out, alloc0_ROBNum_out, alloc1_ROBNum_out,
               retire0_valid_out, retire1_valid_out, retire0_PC_out, retire1_PC_out,
               retire0_archReg_out, retire1_archReg_out, retire0_physReg_out, retire1_physReg_out,
               retire0_oldPhysReg_out, retire1_oldPhysReg_out, retire0_data_out, retire1_data_out,
               retire0_wen_out, retire1_wen_out, retire0_isStore_out, retire1_isStore_out,
               rob_empty_out
    );

    modport slave (
        input  alloc0_valid_in, alloc1_valid_in, alloc0_PC_in, alloc1_PC_in,
               alloc0_archReg_in, alloc1_archReg_in, alloc0_destReg_in, alloc1_destReg_in,
               alloc0_oldDestReg_in, alloc1_oldDestReg_in, alloc0_isStore_in, alloc1_isStore_in,
               PC_complete0_in, PC_complete1_in, PC_complete2_in,
               ROBNum_complete0_in, ROBNum_complete1_in, ROBNum_complete2_in,
               destReg_data_complete0_in, destReg_data_complete1_in, destReg_data_complete2_in,
        output alloc_ready_out, alloc0_ROBNum_out, alloc1_ROBNum_out,
               retire0_valid_out, retire1_valid_out, retire0_PC_out, retire1_PC_out,
               retire0_archReg_out, retire1_archReg_out, retire0_physReg_out, retire1_physReg_out,
               retire0_oldPhysReg_out, retire1_oldPhysReg_out, retire0_data_out, retire1_data_out,
               retire0_wen_out, retire1_wen_out, retire0_isStore_out, retire1_isStore_out,
               rob_empty_out
    );
endinterface

// File: rtl/rob_retire_unit.sv
// In-order reorder buffer: allocates up to 2 entries per cycle at dispatch, marks entries
// complete from three complete ports, retires up to 2 completed entries per cycle in order.
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   bus        rob_retire_unit_if.slave (dispatch, complete and retire signals)
// Optional (macro ROB_PERF_CNT_EN):
//   retired_count_out     total entries retired, wraps at 2^32
//   full_stall_count_out  cycles with an allocation request while not ready
module rob_retire_unit #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned PTR_W = 6
) (
    input  logic                    clk,
    input  logic                    rstn,
`ifdef ROB_PERF_CNT_EN
    output logic [31:0]             retired_count_out,
    output logic [31:0]             full_stall_count_out,
`endif
    rob_retire_unit_if.slave        bus
);
    typedef logic [PTR_W-1:0] ptr_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  arch;
        logic [5:0]  phys;
        logic [5:0]  old_phys;
        logic [31:0] data;
        logic        wen;
        logic        is_store;
    } retire_t;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] complete_q;
    logic [DEPTH-1:0] store_q;
    logic [31:0]      pc_q   [DEPTH];
    logic [4:0]       arch_q [DEPTH];
    logic [5:0]       dest_q [DEPTH];
    logic [5:0]       old_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    ptr_t             head_q, tail_q;
    logic [PTR_W:0]   count_q;
    retire_t          ret0_q, ret1_q, ret0_d, ret1_d;

    ptr_t        head1, tail1, slot1;
    logic        alloc_ready, do_alloc0, do_alloc1, do_ret0, do_ret1;
    logic [1:0]  n_alloc, n_ret;
    logic [2:0]  cmp_valid;
    ptr_t        cmp_num  [3];
    logic [31:0] cmp_data [3];

    assign head1       = head_q + ptr_t'(1);
    assign tail1       = tail_q + ptr_t'(1);
    assign alloc_ready = count_q <= (PTR_W+1)'(DEPTH - 2);
    assign do_alloc0   = alloc_ready && bus.alloc0_valid_in;
    assign do_alloc1   = alloc_ready && bus.alloc1_valid_in;
    // A lone slot-1 request takes the tail entry.
    assign slot1       = do_alloc0 ? tail1 : tail_q;
    assign n_alloc     = {1'b0, do_alloc0} + {1'b0, do_alloc1};

    assign do_ret0 = valid_q[head_q] && complete_q[head_q];
    assign do_ret1 = do_ret0 && valid_q[head1] && complete_q[head1];
    assign n_ret   = {1'b0, do_ret0} + {1'b0, do_ret1};

    assign cmp_valid   = {bus.PC_complete2_in != '0, bus.PC_complete1_in != '0,
                          bus.PC_complete0_in != '0};
    assign cmp_num[0]  = ptr_t'(bus.ROBNum_complete0_in);
    assign cmp_num[1]  = ptr_t'(bus.ROBNum_complete1_in);
    assign cmp_num[2]  = ptr_t'(bus.ROBNum_complete2_in);
    assign cmp_data[0] = bus.destReg_data_complete0_in;
    assign cmp_data[1] = bus.destReg_data_complete1_in;
    assign cmp_data[2] = bus.destReg_data_complete2_in;

    function automatic retire_t entry_view(ptr_t idx);
        retire_t r;
        r.valid    = 1'b1;
        r.pc       = pc_q[idx];
        r.arch     = arch_q[idx];
        r.phys     = dest_q[idx];
        r.old_phys = old_q[idx];
        r.data     = data_q[idx];
        r.wen      = dest_q[idx] != '0;
        r.is_store = store_q[idx];
        return r;
    endfunction

    always_comb begin
        ret0_d = '0;
        ret1_d = '0;
        if (do_ret0) ret0_d = entry_view(head_q);
        if (do_ret1) ret1_d = entry_view(head1);
    end

    // Control state. Slots being allocated are invalid pre-edge, so they never collide with
    // a completing or retiring entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q    <= '0;
            complete_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ret0_q     <= '0;
            ret1_q     <= '0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (cmp_valid[p] && valid_q[cmp_num[p]] && !complete_q[cmp_num[p]]) begin
                    complete_q[cmp_num[p]] <= 1'b1;
                end
            end
            if (do_ret0) valid_q[head_q] <= 1'b0;
            if (do_ret1) valid_q[head1] <= 1'b0;
            if (do_alloc0) begin
                valid_q[tail_q]    <= 1'b1;
                complete_q[tail_q] <= 1'b0;
            end
            if (do_alloc1) begin
                valid_q[slot1]    <= 1'b1;
                complete_q[slot1] <= 1'b0;
            end
            head_q  <= head_q + ptr_t'(n_ret);
            tail_q  <= tail_q + ptr_t'(n_alloc);
            count_q <= count_q + (PTR_W+1)'(n_alloc) - (PTR_W+1)'(n_ret);
            ret0_q  <= ret0_d;
            ret1_q  <= ret1_d;
        end
    end

    // Payload needs no reset: it is only read through valid entries.
    always_ff @(posedge clk) begin
        // Descending port order so the lowest port's write lands last and wins.
        for (int p = 2; p >= 0; p--) begin
            if (cmp_valid[p] && valid_q[cmp_num[p]] && !complete_q[cmp_num[p]]) begin
                data_q[cmp_num[p]] <= cmp_data[p];
            end
        end
        if (do_alloc0) begin
            pc_q[tail_q]    <= bus.alloc0_PC_in;
            arch_q[tail_q]  <= bus.alloc0_archReg_in;
            dest_q[tail_q]  <= bus.alloc0_destReg_in;
            old_q[tail_q]   <= bus.alloc0_oldDestReg_in;
            store_q[tail_q] <= bus.alloc0_isStore_in;
        end
        if (do_alloc1) begin
            pc_q[slot1]    <= bus.alloc1_PC_in;
            arch_q[slot1]  <= bus.alloc1_archReg_in;
            dest_q[slot1]  <= bus.alloc1_destReg_in;
            old_q[slot1]   <= bus.alloc1_oldDestReg_in;
            store_q[slot1] <= bus.alloc1_isStore_in;
        end
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] retired_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            retired_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_q + 32'(n_ret);
            if ((bus.alloc0_valid_in || bus.alloc1_valid_in) && !alloc_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign retired_count_out    = retired_cnt_q;
    assign full_stall_count_out = stall_cnt_q;
`endif

    assign bus.alloc_ready_out   = alloc_ready;
    assign bus.alloc0_ROBNum_out = 6'(tail_q);
    assign bus.alloc1_ROBNum_out = 6'(tail1);
    assign bus.rob_empty_out     = count_q == '0;

    assign bus.retire0_valid_out      = ret0_q.valid;
    assign bus.retire0_PC_out         = ret0_q.pc;
    assign bus.retire0_archReg_out    = ret0_q.arch;
    assign bus.retire0_physReg_out    = ret0_q.phys;
    assign bus.retire0_oldPhysReg_out = ret0_q.old_phys;
    assign bus.retire0_data_out       = ret0_q.data;
    assign bus.retire0_wen_out        = ret0_q.wen;
    assign bus.retire0_isStore_out    = ret0_q.is_store;
    assign bus.retire1_valid_out      = ret1_q.valid;
    assign bus.retire1_PC_out         = ret1_q.pc;
    assign bus.retire1_archReg_out    = ret1_q.arch;
    assign bus.retire1_physReg_out    = ret1_q.phys;
    assign bus.retire1_oldPhysReg_out = ret1_q.old_phys;
    assign bus.retire1_data_out       = ret1_q.data;
    assign bus.retire1_wen_out        = ret1_q.wen;
    assign bus.retire1_isStore_out    = ret1_q.is_store;
endmodule

// File: tb/tb_rob_retire_unit.sv
// Self-checking bench for rob_retire_unit: directed scenarios plus randomized traffic,
// compared against a program-order queue model of the reorder buffer.
module tb_rob_retire_unit;
    localparam int D = 64;
    typedef logic [83:0] slot_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    rob_retire_unit_if bus ();

`ifdef ROB_PERF_CNT_EN
    logic [31:0] retired_count, stall_count;
`endif

    rob_retire_unit #(
        .DEPTH(64),
        .PTR_W(6)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
`ifdef ROB_PERF_CNT_EN
        .retired_count_out   (retired_count),
        .full_stall_count_out(stall_count),
`endif
        .bus                 (bus)
    );

    int n_pass = 0;
    int n_checks = 0;

    // Reference model: entries in flight listed oldest first, plus per-entry records.
    int          m_q[$];
    int          m_tail;
    bit          m_live [D];
    bit          m_cplt [D];
    logic [31:0] m_pc   [D];
    logic [31:0] m_data [D];
    logic [4:0]  m_arch [D];
    logic [5:0]  m_dest [D];
    logic [5:0]  m_old  [D];
    logic        m_st   [D];
    int unsigned m_retired, m_stall;

    bit          seen3, seen4;
    logic [31:0] seen3_data;
    logic        seen4_st, seen4_wen;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_tail = 0;
        for (int e = 0; e < D; e++) begin
            m_live[e] = 0;
            m_cplt[e] = 0;
        end
        m_retired = 0;
        m_stall   = 0;
    endtask

    task automatic clear_inputs();
        bus.alloc0_valid_in = 0; bus.alloc1_valid_in = 0;
        bus.alloc0_PC_in = 0; bus.alloc1_PC_in = 0;
        bus.alloc0_archReg_in = 0; bus.alloc1_archReg_in = 0;
        bus.alloc0_destReg_in = 0; bus.alloc1_destReg_in = 0;
        bus.alloc0_oldDestReg_in = 0; bus.alloc1_oldDestReg_in = 0;
        bus.alloc0_isStore_in = 0; bus.alloc1_isStore_in = 0;
        bus.PC_complete0_in = 0; bus.PC_complete1_in = 0; bus.PC_complete2_in = 0;
        bus.ROBNum_complete0_in = 0; bus.ROBNum_complete1_in = 0; bus.ROBNum_complete2_in = 0;
        bus.destReg_data_complete0_in = 0; bus.destReg_data_complete1_in = 0;
        bus.destReg_data_complete2_in = 0;
    endtask

    task automatic set_alloc(input int slot, input logic [31:0] pc, input logic [4:0] arch,
                             input logic [5:0] dest, input logic [5:0] old, input logic st);
        if (slot == 0) begin
            bus.alloc0_valid_in = 1; bus.alloc0_PC_in = pc; bus.alloc0_archReg_in = arch;
            bus.alloc0_destReg_in = dest; bus.alloc0_oldDestReg_in = old;
            bus.alloc0_isStore_in = st;
        end else begin
            bus.alloc1_valid_in = 1; bus.alloc1_PC_in = pc; bus.alloc1_archReg_in = arch;
            bus.alloc1_destReg_in = dest; bus.alloc1_oldDestReg_in = old;
            bus.alloc1_isStore_in = st;
        end
    endtask

    task automatic set_comp(input int port, input logic [31:0] pc, input logic [5:0] num,
                            input logic [31:0] data);
        case (port)
            0: begin bus.PC_complete0_in = pc; bus.ROBNum_complete0_in = num;
                     bus.destReg_data_complete0_in = data; end
            1: begin bus.PC_complete1_in = pc; bus.ROBNum_complete1_in = num;
                     bus.destReg_data_complete1_in = data; end
            default: begin bus.PC_complete2_in = pc; bus.ROBNum_complete2_in = num;
                     bus.destReg_data_complete2_in = data; end
        endcase
    endtask

    function automatic slot_t pack_entry(input int e);
        return {1'b1, m_pc[e], m_arch[e], m_dest[e], m_old[e], m_data[e], m_dest[e] != 6'd0,
                m_st[e]};
    endfunction

    function automatic slot_t obs0();
        return {bus.retire0_valid_out, bus.retire0_PC_out, bus.retire0_archReg_out,
                bus.retire0_physReg_out, bus.retire0_oldPhysReg_out, bus.retire0_data_out,
                bus.retire0_wen_out, bus.retire0_isStore_out};
    endfunction

    function automatic slot_t obs1();
        return {bus.retire1_valid_out, bus.retire1_PC_out, bus.retire1_archReg_out,
                bus.retire1_physReg_out, bus.retire1_oldPhysReg_out, bus.retire1_data_out,
                bus.retire1_wen_out, bus.retire1_isStore_out};
    endfunction

    task automatic push_entry(input logic [31:0] pc, input logic [4:0] arch,
                              input logic [5:0] dest, input logic [5:0] old, input logic st);
        m_live[m_tail] = 1; m_cplt[m_tail] = 0;
        m_pc[m_tail] = pc; m_arch[m_tail] = arch; m_dest[m_tail] = dest;
        m_old[m_tail] = old; m_st[m_tail] = st;
        m_q.push_back(m_tail);
        m_tail = (m_tail + 1) % D;
    endtask

    // Predicts one clock edge from the current inputs, advances the clock, checks outputs.
    task automatic tick();
        slot_t       e0, e1;
        int          pre, nret;
        logic [31:0] cpc [3];
        logic [31:0] cdat [3];
        int          cnum [3];
        e0 = '0; e1 = '0;
        pre = m_q.size();
        nret = 0;
        if (pre > 0 && m_cplt[m_q[0]]) nret = 1;
        if (nret == 1 && pre > 1 && m_cplt[m_q[1]]) nret = 2;
        if (nret >= 1) begin e0 = pack_entry(m_q[0]); m_live[m_q[0]] = 0; void'(m_q.pop_front()); end
        if (nret == 2) begin e1 = pack_entry(m_q[0]); m_live[m_q[0]] = 0; void'(m_q.pop_front()); end
        cpc[0] = bus.PC_complete0_in; cnum[0] = int'(bus.ROBNum_complete0_in);
        cpc[1] = bus.PC_complete1_in; cnum[1] = int'(bus.ROBNum_complete1_in);
        cpc[2] = bus.PC_complete2_in; cnum[2] = int'(bus.ROBNum_complete2_in);
        cdat[0] = bus.destReg_data_complete0_in;
        cdat[1] = bus.destReg_data_complete1_in;
        cdat[2] = bus.destReg_data_complete2_in;
        for (int p = 0; p < 3; p++) begin
            if (cpc[p] != 0 && m_live[cnum[p]] && !m_cplt[cnum[p]]) begin
                m_cplt[cnum[p]] = 1;
                m_data[cnum[p]] = cdat[p];
            end
        end
        if (pre <= D - 2) begin
            if (bus.alloc0_valid_in)
                push_entry(bus.alloc0_PC_in, bus.alloc0_archReg_in, bus.alloc0_destReg_in,
                           bus.alloc0_oldDestReg_in, bus.alloc0_isStore_in);
            if (bus.alloc1_valid_in)
                push_entry(bus.alloc1_PC_in, bus.alloc1_archReg_in, bus.alloc1_destReg_in,
                           bus.alloc1_oldDestReg_in, bus.alloc1_isStore_in);
        end else if (bus.alloc0_valid_in || bus.alloc1_valid_in) begin
            m_stall++;
        end
        m_retired += nret;

        @(posedge clk);
        #1;
        check("ret0", obs0(), e0);
        check("ret1", obs1(), e1);
        check("ready", bus.alloc_ready_out, m_q.size() <= D - 2);
        check("empty", bus.rob_empty_out, m_q.size() == 0);
        check("robnum0", bus.alloc0_ROBNum_out, m_tail);
        check("robnum1", bus.alloc1_ROBNum_out, (m_tail + 1) % D);
        if (bus.retire0_valid_out && bus.retire0_PC_out == 32'h300) begin
            seen3 = 1; seen3_data = bus.retire0_data_out;
        end
        if (bus.retire1_valid_out && bus.retire1_PC_out == 32'h300) begin
            seen3 = 1; seen3_data = bus.retire1_data_out;
        end
        if (bus.retire0_valid_out && bus.retire0_PC_out == 32'h400) begin
            seen4 = 1; seen4_st = bus.retire0_isStore_out; seen4_wen = bus.retire0_wen_out;
        end
        clear_inputs();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ret0"}, obs0(), '0);
        check({tag, "_ret1"}, obs1(), '0);
        check({tag, "_empty"}, bus.rob_empty_out, 1'b1);
        check({tag, "_ready"}, bus.alloc_ready_out, 1'b1);
        check({tag, "_robnum0"}, bus.alloc0_ROBNum_out, 6'd0);
        check({tag, "_robnum1"}, bus.alloc1_ROBNum_out, 6'd1);
    endtask

    task automatic do_reset(input string tag);
        rstn = 0;
        #1;
        check_reset(tag);
        model_reset();
        #2;
        rstn = 1;
    endtask

    // Completes outstanding entries oldest first until the model is empty, within a budget.
    task automatic drain(input int budget);
        int n;
        for (int c = 0; c < budget && m_q.size() != 0; c++) begin
            n = 0;
            foreach (m_q[i]) begin
                if (n < 3 && !m_cplt[m_q[i]]) begin
                    set_comp(n, $urandom | 32'h1, 6'(m_q[i]), $urandom);
                    n++;
                end
            end
            tick();
        end
        check("drain_empty", bus.rob_empty_out, 1'b1);
    endtask

    task automatic random_cycle(input int comp_pct);
        if ($urandom_range(99) < 60)
            set_alloc(0, $urandom, 5'($urandom), 6'($urandom), 6'($urandom), 1'($urandom));
        if ($urandom_range(99) < 50)
            set_alloc(1, $urandom, 5'($urandom), 6'($urandom), 6'($urandom), 1'($urandom));
        for (int p = 0; p < 3; p++) begin
            if ($urandom_range(99) < comp_pct) begin
                if (m_q.size() > 0 && $urandom_range(7) != 0)
                    set_comp(p, $urandom, 6'(m_q[$urandom_range(m_q.size() - 1)]), $urandom);
                else
                    set_comp(p, $urandom, 6'($urandom), $urandom);
            end
        end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        seen3 = 0; seen4 = 0; seen3_data = 0; seen4_st = 0; seen4_wen = 1;
        clear_inputs();
        rstn = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        rstn = 1;

        // Two allocations, out-of-order completion, paired retire.
        set_alloc(0, 32'h100, 5'd1, 6'd5, 6'd33, 1'b0);
        set_alloc(1, 32'h104, 5'd2, 6'd6, 6'd34, 1'b0);
        tick();
        check("t1_robnum0", bus.alloc0_ROBNum_out, 6'd2);
        check("t1_empty", bus.rob_empty_out, 1'b0);
        set_comp(0, 32'h104, 6'd1, 32'hAA);
        tick();
        check("t2_noret_rob1", bus.retire0_valid_out, 1'b0);
        set_comp(0, 32'h100, 6'd0, 32'h55);
        tick();
        check("t2_no_bypass", bus.retire0_valid_out, 1'b0);
        tick();
        check("t2_pc0", bus.retire0_PC_out, 32'h100);
        check("t2_data0", bus.retire0_data_out, 32'h55);
        check("t2_pc1", bus.retire1_PC_out, 32'h104);
        check("t2_data1", bus.retire1_data_out, 32'hAA);

        // Fill to 63 entries; further requests are ignored.
        for (int i = 0; i < 31; i++) begin
            set_alloc(0, 32'h1000 + 8 * i, 5'(i), 6'(i + 1), 6'(i), 1'b0);
            set_alloc(1, 32'h1004 + 8 * i, 5'(i + 1), 6'(i + 2), 6'(i + 1), 1'b0);
            tick();
        end
        check("t3_ready_at62", bus.alloc_ready_out, 1'b1);
        set_alloc(0, 32'h2000, 5'd3, 6'd9, 6'd8, 1'b0);
        tick();
        check("t3_ready_low", bus.alloc_ready_out, 1'b0);
        set_alloc(0, 32'h3000, 5'd4, 6'd10, 6'd11, 1'b0);
        set_alloc(1, 32'h3004, 5'd5, 6'd12, 6'd13, 1'b0);
        tick();
        check("t3_tail_held", bus.alloc0_ROBNum_out, 6'd1);
        drain(100);

        // Same-entry multi-port completion and store commit.
        do_reset("rst_t5");
        set_alloc(0, 32'h10, 5'd1, 6'd7, 6'd1, 1'b0);
        set_alloc(1, 32'h14, 5'd2, 6'd8, 6'd2, 1'b0);
        tick();
        set_alloc(0, 32'h18, 5'd3, 6'd9, 6'd3, 1'b0);
        set_alloc(1, 32'h300, 5'd4, 6'd10, 6'd4, 1'b0);
        tick();
        set_alloc(0, 32'h400, 5'd0, 6'd0, 6'd0, 1'b1);
        tick();
        set_comp(0, 32'h10, 6'd0, 32'h1);
        set_comp(1, 32'h14, 6'd1, 32'h2);
        set_comp(2, 32'h18, 6'd2, 32'h3);
        tick();
        set_comp(0, 32'h300, 6'd3, 32'h11);
        set_comp(2, 32'h300, 6'd3, 32'h22);
        tick();
        set_comp(1, 32'h300, 6'd3, 32'h33);
        set_comp(2, 32'h400, 6'd4, 32'hDEAD);
        tick();
        repeat (3) tick();
        check("t5_rob3_seen", seen3, 1'b1);
        check("t5_rob3_data", seen3_data, 32'h11);
        check("t5_store_seen", seen4, 1'b1);
        check("t5_store_flag", seen4_st, 1'b1);
        check("t5_store_wen", seen4_wen, 1'b0);

        // Randomized traffic: a congested phase, a reset mid-stream, then a flowing phase.
        for (int c = 0; c < 250; c++) random_cycle(25);
        do_reset("rst_mid");
        for (int c = 0; c < 350; c++) random_cycle(80);
        drain(300);

`ifdef ROB_PERF_CNT_EN
        check("perf_retired", retired_count, m_retired);
        check("perf_stall", stall_count, m_stall);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
